dsd_decim_fir: RTL and testbench

//  Parametrised multi-channel DSD->PCM FIR decimator, successor to the fixed 2-ch/160-tap unit.

---
 rtl/dsd_decim_fir.sv | 137 +++++++++++++
 tb/tb_dsd_decim_fir.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsd_decim_fir.sv
// Multi-channel DSD->PCM FIR decimator with double-buffered, run-time loadable coefficients.
// LANES taps per channel are accumulated each clock during the first NTAP/LANES phases of a frame.
module dsd_decim_fir #(
  parameter int NCH   = 2,
  parameter int NTAP  = 160,
  parameter int LANES = 10,
  parameter int DECIM = 32,
  parameter int CW    = 24,
  parameter int ACCW  = 40,
  parameter int SHIFT = 8,
  parameter int OW    = 32
) (
  input  logic                    deci_bck,
  input  logic                    reset,
  input  logic [NCH-1:0]          dsd_in,
  input  logic                    coef_we,
  input  logic [$clog2(NTAP)-1:0] coef_addr,
  input  logic [CW-1:0]           coef_wdata,
  input  logic                    coef_swap,
  output logic                    swap_busy,
  output logic [NCH*OW-1:0]       pcm_out,
  output logic                    pcm_valid,
  output logic [NCH-1:0]          pcm_sat
);
  localparam int NCYC = NTAP / LANES;
  localparam int AW   = $clog2(NTAP);
  localparam int PW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [PW-1:0] PH_OUT  = PW'(NCYC - 1);
  localparam logic signed [ACCW-1:0] OMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [NTAP-1:0]        hist [NCH];
  logic [NTAP-1:0]        snap [NCH];
  logic [CW-1:0]          bank [2][NTAP];
  logic                   act, primed;
  logic [PW-1:0]          phase;
  logic signed [ACCW-1:0] acc [NCH];
  logic signed [ACCW-1:0] sum [NCH];
  logic signed [ACCW-1:0] shf [NCH];
  logic [LANES-1:0][CW-1:0]            lane_c;
  logic [NCH-1:0][LANES-1:0]           lane_x;
  logic [NCH-1:0][LANES-1:0][ACCW-1:0] lane_t;
  logic [NCH-1:0][OW-1:0] sat_y;
  logic [NCH-1:0]         sat_f;
  logic                   frame, compute;
  int                     ti;

  assign frame   = (phase == PH_LAST);
  // primed blocks the compute window until a real snapshot exists after reset
  assign compute = primed && (int'(phase) < NCYC);

  always_comb begin
    lane_c = '0;
    lane_x = '0;
    ti     = 0;
    for (int l = 0; l < LANES; l++) begin
      ti = int'(phase) * LANES + l;
      if (ti < NTAP) begin
        lane_c[l] = bank[act][AW'(ti)];
        for (int c = 0; c < NCH; c++) lane_x[c][l] = snap[c][AW'(ti)];
      end
    end
  end

  for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      logic [ACCW-1:0] cx;
      assign cx = {{(ACCW-CW){lane_c[gl][CW-1]}}, lane_c[gl]};
      assign lane_t[gc][gl] = lane_x[gc][gl] ? cx : -cx;
    end
  end

  always_comb begin
    sat_y = '0;
    sat_f = '0;
    for (int c = 0; c < NCH; c++) begin
      sum[c] = acc[c];
      for (int l = 0; l < LANES; l++) sum[c] = sum[c] + $signed(lane_t[c][l]);
      shf[c] = sum[c] >>> SHIFT;
      if (shf[c] > OMAX) begin
        sat_y[c] = OMAX[OW-1:0];
        sat_f[c] = 1'b1;
      end else if (shf[c] < OMIN) begin
        sat_y[c] = OMIN[OW-1:0];
        sat_f[c] = 1'b1;
      end else begin
        sat_y[c] = shf[c][OW-1:0];
      end
    end
  end

  always_ff @(posedge deci_bck or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      primed    <= 1'b0;
      act       <= 1'b0;
      swap_busy <= 1'b0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      pcm_sat   <= '0;
      for (int c = 0; c < NCH; c++) begin
        hist[c] <= '0;
        snap[c] <= '0;
        acc[c]  <= '0;
      end
      for (int b = 0; b < 2; b++)
        for (int n = 0; n < NTAP; n++) bank[b][n] <= '0;
    end else begin
      phase     <= frame ? '0 : phase + 1'b1;
      pcm_valid <= 1'b0;
      for (int c = 0; c < NCH; c++) hist[c] <= {hist[c][NTAP-2:0], dsd_in[c]};
      // uses the pre-swap act, so a write on the frame edge lands in the old shadow
      if (coef_we && int'(coef_addr) < NTAP) bank[~act][coef_addr] <= coef_wdata;
      if (compute) begin
        for (int c = 0; c < NCH; c++) acc[c] <= sum[c];
        if (phase == PH_OUT) begin
          pcm_valid <= 1'b1;
          pcm_out   <= sat_y;
          pcm_sat   <= sat_f;
        end
      end
      if (coef_swap && !swap_busy) swap_busy <= 1'b1;
      if (frame) begin
        primed <= 1'b1;
        for (int c = 0; c < NCH; c++) begin
          snap[c] <= {hist[c][NTAP-2:0], dsd_in[c]};
          acc[c]  <= '0;
        end
        if (swap_busy) begin
          act       <= ~act;
          swap_busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dsd_decim_fir.sv
// Bench for dsd_decim_fir: queue-based reference model of the FIR/decimation/swap rules,
// checked every clock, plus fixed expected values for the directed scenarios.
module tb_dsd_decim_fir;
  localparam int NCH = 2, NTAP = 160, LANES = 10, DECIM = 32, CW = 24, ACCW = 40, SHIFT = 0, OW = 16;
  localparam int NCYC = NTAP / LANES;
  localparam int AW = $clog2(NTAP);

  logic              deci_bck = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    dsd_in = '0;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [CW-1:0]     coef_wdata = '0;
  logic              coef_swap = 1'b0;
  logic              swap_busy, pcm_valid;
  logic [NCH*OW-1:0] pcm_out;
  logic [NCH-1:0]    pcm_sat;

  dsd_decim_fir #(.NCH(NCH), .NTAP(NTAP), .LANES(LANES), .DECIM(DECIM), .CW(CW),
                  .ACCW(ACCW), .SHIFT(SHIFT), .OW(OW)) dut (
    .deci_bck(deci_bck), .reset(reset), .dsd_in(dsd_in), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
    .swap_busy(swap_busy), .pcm_out(pcm_out), .pcm_valid(pcm_valid), .pcm_sat(pcm_sat));

  always #5 deci_bck = ~deci_bck;

  int n_tests = 0, n_fail = 0;

  // reference model state
  bit     hq[NCH][$];
  longint cm[2][NTAP];
  int     act_m;
  bit     busy_m;
  longint e;
  longint pend_due;
  longint pend_y[NCH];
  bit     pend_s[NCH];
  bit     m_valid;
  longint m_y[NCH];
  bit     m_s[NCH];

  function automatic longint chan(input int c);
    return longint'($signed(pcm_out[c*OW +: OW]));
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      hq[c].delete();
      pend_y[c] = 0; pend_s[c] = 0; m_y[c] = 0; m_s[c] = 0;
    end
    for (int b = 0; b < 2; b++) for (int n = 0; n < NTAP; n++) cm[b][n] = 0;
    act_m = 0; busy_m = 0; e = 0; pend_due = -1; m_valid = 0;
  endfunction

  function automatic void model_edge(input logic [NCH-1:0] d, input bit we, input int addr,
                                     input longint data, input bit sw);
    longint y, maxv, minv;
    bit xb;
    maxv = (longint'(1) <<< (OW-1)) - 1;
    minv = -(longint'(1) <<< (OW-1));
    for (int c = 0; c < NCH; c++) begin
      hq[c].push_front(d[c]);
      if (hq[c].size() > NTAP) void'(hq[c].pop_back());
    end
    m_valid = (pend_due == e);
    if (m_valid) for (int c = 0; c < NCH; c++) begin m_y[c] = pend_y[c]; m_s[c] = pend_s[c]; end
    if (we && addr < NTAP) cm[1-act_m][addr] = data;
    if (e % DECIM == DECIM-1) begin
      if (busy_m) begin act_m = 1 - act_m; busy_m = 0; end
      else if (sw) busy_m = 1;
      for (int c = 0; c < NCH; c++) begin
        y = 0;
        for (int n = 0; n < NTAP; n++) begin
          xb = (n < hq[c].size()) ? hq[c][n] : 1'b0;
          y += xb ? cm[act_m][n] : -cm[act_m][n];
        end
        y = y >>> SHIFT;
        pend_s[c] = (y > maxv) || (y < minv);
        pend_y[c] = (y > maxv) ? maxv : (y < minv) ? minv : y;
      end
      pend_due = e + NCYC;
    end else if (sw) busy_m = 1;
    e++;
  endfunction

  task automatic step(input logic [NCH-1:0] d, input bit we, input int addr, input longint data,
                      input bit sw);
    dsd_in = d; coef_we = we; coef_addr = AW'(addr); coef_wdata = CW'(data); coef_swap = sw;
    @(posedge deci_bck);
    model_edge(d, we, addr, data, sw);
    #1;
    coef_we = 1'b0; coef_swap = 1'b0;
  endtask

  // mode 0: constant k, mode 1: c[n]=n+1, mode 2: random
  task automatic load_bank(input int mode, input int k, input logic [NCH-1:0] d);
    longint v;
    for (int n = 0; n < NTAP; n++) begin
      v = (mode == 0) ? longint'(k) : (mode == 1) ? longint'(n + 1)
                                                  : longint'(int'($urandom_range(600)) - 300);
      step(d, 1'b1, n, v, 1'b0);
    end
  endtask

  task automatic swap_now(input logic [NCH-1:0] d);
    step(d, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 2*DECIM && busy_m; i++) step(d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic run_to(input logic [NCH-1:0] d, input int ph);
    for (int i = 0; i < DECIM && (e % DECIM) != ph; i++) step(d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge deci_bck);
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (pcm_out !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", pcm_out); end
    n_tests++; if (pcm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pcm_valid); end
    n_tests++; if (pcm_sat !== '0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", pcm_sat); end
    n_tests++; if (swap_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", swap_busy); end
    repeat (2) @(negedge deci_bck);
    reset = 1'b0;
  endtask

  task automatic test_const();
    longint last, want;
    int zeros;
    logic [NCH-1:0] d;
    last = -1; zeros = 0;
    load_bank(0, 1, 2'b11);
    swap_now(2'b11);
    for (int i = 0; i < 450; i++) begin
      d = (i < 200) ? 2'b11 : 2'b00;
      if (d == 2'b00) zeros++;
      step(d, 1'b0, 0, 0, 1'b0);
      n_tests++; if (pcm_valid !== m_valid) begin n_fail++; $display("FAIL const_valid e=%0d: got %b want %b", e-1, pcm_valid, m_valid); end
      for (int c = 0; c < NCH; c++) begin
        n_tests++; if (chan(c) !== m_y[c] || pcm_sat[c] !== m_s[c]) begin n_fail++; $display("FAIL const_model ch%0d: got %0d/%b want %0d/%b", c, chan(c), pcm_sat[c], m_y[c], m_s[c]); end
      end
      if (pcm_valid === 1'b1) begin
        if (last >= 0) begin
          n_tests++; if (e-1-last != DECIM) begin n_fail++; $display("FAIL const_spacing: got %0d want %0d", e-1-last, DECIM); end
        end
        last = e - 1;
        if (i < 200 || zeros >= NTAP + NCYC) begin
          want = (i < 200) ? 160 : -160;
          for (int c = 0; c < NCH; c++) begin
            n_tests++; if (chan(c) !== want) begin n_fail++; $display("FAIL const_value ch%0d: got %0d want %0d", c, chan(c), want); end
          end
        end
      end
    end
  endtask

  task automatic test_impulse();
    longint p, f, m, want, sumc;
    logic [NCH-1:0] d;
    p = -100000; sumc = NTAP * (NTAP + 1) / 2;
    load_bank(1, 0, 2'b00);
    swap_now(2'b00);
    for (int i = 0; i < 260; i++) begin
      d = (i == 20) ? 2'b01 : 2'b00;
      if (i == 20) p = e;
      step(d, 1'b0, 0, 0, 1'b0);
      n_tests++; if (pcm_valid !== m_valid) begin n_fail++; $display("FAIL imp_valid e=%0d: got %b want %b", e-1, pcm_valid, m_valid); end
      for (int c = 0; c < NCH; c++) begin
        n_tests++; if (chan(c) !== m_y[c]) begin n_fail++; $display("FAIL imp_model ch%0d: got %0d want %0d", c, chan(c), m_y[c]); end
      end
      if (pcm_valid === 1'b1) begin
        f = e - 1 - NCYC;
        m = f - p;
        want = (m >= 0 && m < NTAP) ? -sumc + 2*(m + 1) : -sumc;
        n_tests++; if (chan(0) !== want) begin n_fail++; $display("FAIL imp_ch0 m=%0d: got %0d want %0d", m, chan(0), want); end
        n_tests++; if (chan(1) !== -sumc) begin n_fail++; $display("FAIL imp_ch1: got %0d want %0d", chan(1), -sumc); end
      end
    end
  endtask

  task automatic test_saturation();
    int zeros;
    zeros = 0;
    load_bank(0, 1000, 2'b11);
    swap_now(2'b11);
    for (int i = 0; i < 64; i++) begin
      step(2'b11, 1'b0, 0, 0, 1'b0);
      if (pcm_valid === 1'b1) for (int c = 0; c < NCH; c++) begin
        n_tests++; if (chan(c) !== 32767 || pcm_sat[c] !== 1'b1) begin n_fail++; $display("FAIL sat_max ch%0d: got %0d/%b want 32767/1", c, chan(c), pcm_sat[c]); end
      end
    end
    for (int i = 0; i < 250; i++) begin
      step(2'b00, 1'b0, 0, 0, 1'b0);
      zeros++;
      if (pcm_valid === 1'b1 && zeros >= NTAP + NCYC) for (int c = 0; c < NCH; c++) begin
        n_tests++; if (chan(c) !== -32768 || pcm_sat[c] !== 1'b1) begin n_fail++; $display("FAIL sat_min ch%0d: got %0d/%b want -32768/1", c, chan(c), pcm_sat[c]); end
      end
    end
    load_bank(0, 1, 2'b00);
    swap_now(2'b00);
    for (int i = 0; i < 64; i++) begin
      step(2'b00, 1'b0, 0, 0, 1'b0);
      n_tests++; if (pcm_valid !== m_valid) begin n_fail++; $display("FAIL sat_valid e=%0d: got %b want %b", e-1, pcm_valid, m_valid); end
      if (pcm_valid === 1'b1) for (int c = 0; c < NCH; c++) begin
        n_tests++; if (chan(c) !== -160 || pcm_sat[c] !== 1'b0) begin n_fail++; $display("FAIL sat_clear ch%0d: got %0d/%b want -160/0", c, chan(c), pcm_sat[c]); end
      end
    end
  endtask

  task automatic test_swap();
    bit wb;
    longint want;
    load_bank(0, 2, 2'b11);
    run_to(2'b11, 0);
    for (int i = 0; i < 96; i++) begin
      step(2'b11, 1'b0, 0, 0, i == 5);
      wb = (i >= 5 && i < 31);
      n_tests++; if (swap_busy !== wb) begin n_fail++; $display("FAIL swap_busy i=%0d: got %b want %b", i, swap_busy, wb); end
      n_tests++; if (pcm_valid !== m_valid) begin n_fail++; $display("FAIL swap_valid i=%0d: got %b want %b", i, pcm_valid, m_valid); end
      if (i == 15 || i == 47 || i == 79) begin
        want = (i == 15) ? 160 : 320;
        for (int c = 0; c < NCH; c++) begin
          n_tests++; if (pcm_valid !== 1'b1 || chan(c) !== want) begin n_fail++; $display("FAIL swap_value i=%0d ch%0d: got %0d/%b want %0d/1", i, c, chan(c), pcm_valid, want); end
        end
      end
    end
  endtask

  task automatic test_edge_cases();
    bit wb, sw;
    longint want;
    run_to(2'b11, 0);
    for (int i = 0; i < 160; i++) begin
      sw = (i == 31 || i == 67 || i == 74 || i == 84);
      step(2'b11, i == 10, NTAP, 999, sw);
      wb = (i >= 31 && i < 63) || (i >= 67 && i < 95);
      n_tests++; if (swap_busy !== wb) begin n_fail++; $display("FAIL edge_busy i=%0d: got %b want %b", i, swap_busy, wb); end
      n_tests++; if (swap_busy !== busy_m) begin n_fail++; $display("FAIL edge_busy_model i=%0d: got %b want %b", i, swap_busy, busy_m); end
      if (i == 47 || i == 79 || i == 111 || i == 143) begin
        want = (i == 79) ? 160 : 320;
        for (int c = 0; c < NCH; c++) begin
          n_tests++; if (pcm_valid !== 1'b1 || chan(c) !== want) begin n_fail++; $display("FAIL edge_value i=%0d ch%0d: got %0d/%b want %0d/1", i, c, chan(c), pcm_valid, want); end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] d;
    load_bank(2, 0, 2'b10);
    swap_now(2'b01);
    for (int i = 0; i < 500; i++) begin
      d = NCH'($urandom);
      step(d, ($urandom % 4) == 0, int'($urandom_range(NTAP + 15)),
           longint'(int'($urandom_range(600)) - 300), ($urandom % 50) == 0);
      n_tests++; if (pcm_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid e=%0d: got %b want %b", e-1, pcm_valid, m_valid); end
      n_tests++; if (swap_busy !== busy_m) begin n_fail++; $display("FAIL rand_busy e=%0d: got %b want %b", e-1, swap_busy, busy_m); end
      for (int c = 0; c < NCH; c++) begin
        n_tests++; if (chan(c) !== m_y[c] || pcm_sat[c] !== m_s[c]) begin n_fail++; $display("FAIL rand_model ch%0d e=%0d: got %0d/%b want %0d/%b", c, e-1, chan(c), pcm_sat[c], m_y[c], m_s[c]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    longint first_v;
    first_v = -1;
    run_to(2'b11, 0);
    for (int i = 0; i <= 5; i++) step(2'b11, 1'b0, 0, 0, i == 2);
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (pcm_out !== '0) begin n_fail++; $display("FAIL rmid_out: got %h want 0", pcm_out); end
    n_tests++; if (pcm_sat !== '0 || swap_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got sat=%b busy=%b want 0/0", pcm_sat, swap_busy); end
    repeat (3) begin
      @(posedge deci_bck); #1;
      n_tests++; if (pcm_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_strobe: got %b want 0", pcm_valid); end
    end
    @(negedge deci_bck);
    reset = 1'b0;
    for (int i = 0; i < DECIM + NCYC + 8; i++) begin
      step(NCH'($urandom), 1'b0, 0, 0, 1'b0);
      n_tests++; if (pcm_valid !== m_valid) begin n_fail++; $display("FAIL rmid_valid e=%0d: got %b want %b", e-1, pcm_valid, m_valid); end
      if (pcm_valid === 1'b1 && first_v < 0) begin
        first_v = e - 1;
        for (int c = 0; c < NCH; c++) begin
          n_tests++; if (chan(c) !== 0) begin n_fail++; $display("FAIL rmid_value ch%0d: got %0d want 0", c, chan(c)); end
        end
      end
    end
    n_tests++; if (first_v != DECIM - 1 + NCYC) begin n_fail++; $display("FAIL rmid_latency: got %0d want %0d", first_v, DECIM - 1 + NCYC); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_const();
    test_impulse();
    test_saturation();
    test_swap();
    test_edge_cases();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
